ps2_key_ctrl: RTL and testbench
===============================

# ps2_key_ctrl

Scancode sequencer that sits directly behind the PS/2 frame receiver. It consumes the receiver's validated byte stream and parses Set-2 prefix sequences (E0 extended, F0 break) into key events. It suppresses typematic repeats of the currently held key, counts distinct key presses, and buffers events in a small FIFO with a valid/ready handshake toward the consumer (display/CPU side).

## Interface
- FIFO_DEPTH, 4, event FIFO entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 50000, idle clk cycles tolerated inside a prefix sequence before the parser aborts it to IDLE.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  one-cycle strobe: in_byte holds a frame-checked scancode byte.
- in_byte  in  8  received byte.
- evt_valid  out  1  FIFO non-empty; the head event is on the evt_* outputs.
- evt_ready  in  1  consumer accepts the head event when evt_valid & evt_ready.
- evt_code  out  8  head event scancode (prefixes stripped).
- evt_ext  out  1  head event carried an E0 prefix.
- evt_break  out  1  1 = release, 0 = press.
- key_held  out  1  a key is currently held (last accepted make not yet released).
- held_code  out  9  {ext, code} of the held key.
- press_count  out  8  number of accepted make events; wraps 0xFF -> 0x00.
- overflow  out  1  sticky: an event was dropped because the FIFO was full; cleared only by reset.

## Operation
- Parser FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Transitions happen only on in_valid, except timeout.
- IDLE: E0 -> EXT; F0 -> BRK; bytes 00, AA, E1, EE, FA, FE, FF are discarded and the FSM stays in IDLE; any other byte produces a make event with ext=0 and the FSM stays in IDLE.
- EXT: F0 -> EXT_BRK; E0 -> stays in EXT; a discard-set byte -> IDLE with no event; any other byte -> make event with ext=1, then IDLE.
- BRK: E0 or F0 -> IDLE, no event (protocol error); a discard-set byte -> IDLE; any other byte -> break event with ext=0, then IDLE.
- EXT_BRK: E0, F0 or a discard-set byte -> IDLE with no event; any other byte -> break event with ext=1, then IDLE.
- Timeout: a counter runs while the FSM is not in IDLE. It resets on every in_valid and on entry to a non-IDLE state. When it reaches TIMEOUT_CYCLES-1 without an in_valid, the FSM goes to IDLE and the partial sequence is lost.
- Make filter:
  - A make whose {ext,code} equals held_code while key_held=1 is a typematic repeat. It is dropped: no push, no count.
  - Any other make is pushed, sets held_code and key_held=1, and increments press_count.
- Break handling:
  - Every break is pushed.
  - If its {ext,code} equals held_code while key_held=1, key_held clears and held_code keeps its value.
  - Otherwise held state is unchanged.
- FIFO behaviour:
  - Push occurs when an event is generated.
  - Pop occurs when evt_valid & evt_ready.
  - When full with no pop in the same cycle, the push is dropped and overflow is set. held/press_count still update as if the event had been pushed.
  - When full with a pop in the same cycle, the push succeeds.
  - When empty, a push and a pop cannot coincide because evt_valid=0.
  - Pointers wrap modulo FIFO_DEPTH; the full/empty distinction uses an extra pointer bit or an occupancy counter.
- Reset: FSM to IDLE, timeout counter 0, FIFO emptied, and every output 0 (evt_valid, evt_code, evt_ext, evt_break, key_held, held_code, press_count, overflow). Reset mid-sequence discards the partial prefix.

## Timing
- All outputs are registered.
- in_valid in cycle N that completes an event: the FIFO write, held_code/key_held and press_count updates are visible in cycle N+1. If the FIFO was empty, evt_valid=1 in N+1 with the event on evt_*.
- Prefix bytes (E0, F0) produce no output change.
- Pop in cycle N: the next entry (or evt_valid=0) is visible in N+1. evt_* are stable while evt_valid=1 and evt_ready=0.
- Throughput: one in_valid per cycle is accepted. The receiver delivers far slower, but back-to-back in_valid must work.
- Timeout: with the FSM leaving IDLE in cycle N and no further in_valid, the FSM is in IDLE in cycle N+TIMEOUT_CYCLES.

## Test plan
- Basic press/release: bytes 1C, F0, 1C with evt_ready=1 -> events {1C, ext0, make} then {1C, ext0, break}. press_count=1, key_held=0 at the end.
- Typematic: bytes 1C, 1C, 1C, F0, 1C -> exactly 2 events (make, break), press_count=1. key_held=1 from after the first byte until after the final byte.
- Extended: bytes E0 75, E0 F0 75 -> {75, ext1, make} then {75, ext1, break}. held_code=0x175 while held.
- Overflow: with FIFO_DEPTH=4 and evt_ready=0, send makes 1C, 32, 21, 23, 24 -> evt_valid=1, overflow=1, press_count=5, held_code=0x024. Then raise evt_ready -> exactly 4 events in order 1C, 32, 21, 23, then evt_valid=0.
- Timeout and reset: with TIMEOUT_CYCLES=16, send E0, idle 16 cycles, then 1C -> make with ext=0. Send F0, assert reset for 1 cycle, then 1C -> make (not break), press_count=1.
- Simultaneous push/pop when full: fill 4 entries with evt_ready=0, then present in_valid on the same cycle as the first pop -> no overflow, 4 entries remain, and the newest event is last out.

Source files
------------

// File: rtl/ps2_key_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_key_ctrl: Set-2 scancode parser with repeat filter and event FIFO    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module ps2_key_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       key_held,
  output logic [8:0] held_code,
  output logic [7:0] press_count,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] c_TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] c_TO_ONE  = TW'(1);
  localparam logic [AW:0]   c_PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0]   c_FULL_X  = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t          r_state, w_next;
  logic [TW-1:0]   r_to_cnt;
  logic            w_evt, w_evt_ext, w_evt_brk, w_disc;
  logic            r_key_held, r_overflow;
  logic [8:0]      r_held_code;
  logic [7:0]      r_press_count;
  logic [9:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wr_ptr, r_rd_ptr;
  logic            w_empty, w_full, w_pop, w_match, w_repeat, w_push, w_wr_en;

  always_comb begin
    case (in_byte)
      8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF: w_disc = 1'b1;
      default:                                         w_disc = 1'b0;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_evt     = 1'b0;
    w_evt_ext = 1'b0;
    w_evt_brk = 1'b0;
    if (in_valid) begin
      case (r_state)
        S_IDLE: begin
          if (in_byte == 8'hE0)      w_next = S_EXT;
          else if (in_byte == 8'hF0) w_next = S_BRK;
          else if (!w_disc)          w_evt  = 1'b1;
        end
        S_EXT: begin
          if (in_byte == 8'hF0)      w_next = S_EXT_BRK;
          else if (in_byte == 8'hE0) w_next = S_EXT;
          else begin
            w_next    = S_IDLE;
            w_evt     = !w_disc;
            w_evt_ext = 1'b1;
          end
        end
        default: begin
          // Break states: a second prefix is a protocol error and aborts.
          w_next    = S_IDLE;
          w_evt     = !w_disc && (in_byte != 8'hE0) && (in_byte != 8'hF0);
          w_evt_ext = (r_state == S_EXT_BRK);
          w_evt_brk = 1'b1;
        end
      endcase
    end else if (r_state != S_IDLE && r_to_cnt == c_TO_LAST) begin
      w_next = S_IDLE;
    end
  end

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = ((r_wr_ptr ^ r_rd_ptr) == c_FULL_X);
  assign w_pop    = !w_empty && evt_ready;
  assign w_match  = r_key_held && (r_held_code == {w_evt_ext, in_byte});
  assign w_repeat = w_evt && !w_evt_brk && w_match;
  assign w_push   = w_evt && !w_repeat;
  // A full FIFO still accepts the write when the head leaves in the same cycle.
  assign w_wr_en  = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_to_cnt      <= '0;
      r_key_held    <= 1'b0;
      r_held_code   <= '0;
      r_press_count <= '0;
      r_overflow    <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_state <= w_next;
      if (in_valid || w_next == S_IDLE) r_to_cnt <= '0;
      else                              r_to_cnt <= r_to_cnt + c_TO_ONE;
      if (w_push && !w_evt_brk) begin
        r_key_held    <= 1'b1;
        r_held_code   <= {w_evt_ext, in_byte};
        r_press_count <= r_press_count + 8'd1;
      end else if (w_push && w_match) begin
        r_key_held <= 1'b0;
      end
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {w_evt_brk, w_evt_ext, in_byte};
    end
  end

  assign evt_valid   = !w_empty;
  assign evt_code    = r_mem[r_rd_ptr[AW-1:0]][7:0];
  assign evt_ext     = r_mem[r_rd_ptr[AW-1:0]][8];
  assign evt_break   = r_mem[r_rd_ptr[AW-1:0]][9];
  assign key_held    = r_key_held;
  assign held_code   = r_held_code;
  assign press_count = r_press_count;
  assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ps2_key_ctrl: directed bench for ps2_key_ctrl                         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       evt_ready = 1'b0;
  logic       evt_valid, evt_ext, evt_break, key_held, overflow;
  logic [7:0] evt_code, press_count;
  logic [8:0] held_code;

  int n_assert = 0;
  int n_fail   = 0;

  ps2_key_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_break(evt_break), .key_held(key_held),
    .held_code(held_code), .press_count(press_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Check the head event {break, ext, code} and pop it.
  task automatic pop_expect(input string tag, input logic [9:0] exp);
    chk({tag, "_valid"}, 32'(evt_valid), 32'h1);
    chk({tag, "_evt"}, 32'({evt_break, evt_ext, evt_code}), 32'(exp));
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic chk_held(input string tag, input logic held, input logic [8:0] code,
                          input logic [7:0] cnt);
    chk({tag, "_held"}, 32'(key_held), 32'(held));
    chk({tag, "_code"}, 32'(held_code), 32'(code));
    chk({tag, "_cnt"}, 32'(press_count), 32'(cnt));
  endtask

  initial begin
    idle(2);
    reset = 1'b0;
    chk("rst_outs", 32'({evt_valid, evt_code, evt_ext, evt_break, key_held,
                         held_code, press_count, overflow}), 32'h0);

    // Basic press / release
    send(8'h1C);
    chk_held("basic_mk", 1'b1, 9'h01C, 8'd1);
    pop_expect("basic_mk", 10'h01C);
    send(8'hF0);
    chk("prefix_quiet", 32'(evt_valid), 32'h0);
    send(8'h1C);
    chk_held("basic_br", 1'b0, 9'h01C, 8'd1);
    pop_expect("basic_br", 10'h21C);
    chk("basic_empty", 32'(evt_valid), 32'h0);

    // Typematic repeats, sent back-to-back
    send(8'h1C); send(8'h1C); send(8'h1C);
    chk_held("typ_mid", 1'b1, 9'h01C, 8'd2);
    send(8'hF0); send(8'h1C);
    chk_held("typ_end", 1'b0, 9'h01C, 8'd2);
    pop_expect("typ_mk", 10'h01C);
    pop_expect("typ_br", 10'h21C);
    chk("typ_empty", 32'(evt_valid), 32'h0);

    // Extended key
    send(8'hE0); send(8'h75);
    chk_held("ext_mk", 1'b1, 9'h175, 8'd3);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk_held("ext_br", 1'b0, 9'h175, 8'd3);
    pop_expect("ext_mk", 10'h175);
    pop_expect("ext_br", 10'h375);

    // Discard set and protocol errors
    send(8'hAA);
    chk("disc_idle", 32'(evt_valid), 32'h0);
    send(8'hE0); send(8'hAA); send(8'h1C);
    pop_expect("disc_ext", 10'h01C);
    send(8'hF0); send(8'hE0); send(8'h1C);
    chk("brk_err_rep", 32'(evt_valid), 32'h0);
    chk_held("brk_err", 1'b1, 9'h01C, 8'd4);
    send(8'hF0); send(8'h1C);
    pop_expect("disc_rel", 10'h21C);

    // Overflow with consumer stalled
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    chk("ovf_valid", 32'(evt_valid), 32'h1);
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk_held("ovf", 1'b1, 9'h024, 8'd9);
    pop_expect("ovf0", 10'h01C);
    pop_expect("ovf1", 10'h032);
    pop_expect("ovf2", 10'h021);
    pop_expect("ovf3", 10'h023);
    chk("ovf_empty", 32'(evt_valid), 32'h0);
    send(8'hF0); send(8'h24);
    pop_expect("ovf_rel", 10'h224);

    // Timeout: 15 idle cycles keeps the prefix, 16 drops it
    send(8'hE0); idle(15); send(8'h75);
    pop_expect("to_keep", 10'h175);
    send(8'hE0); idle(16); send(8'h1C);
    pop_expect("to_drop", 10'h01C);
    chk_held("to", 1'b1, 9'h01C, 8'd11);

    // Reset mid-sequence
    send(8'hF0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_outs", 32'({evt_valid, evt_code, evt_ext, evt_break, key_held,
                          held_code, press_count, overflow}), 32'h0);
    send(8'h1C);
    chk_held("rst2_mk", 1'b1, 9'h01C, 8'd1);
    pop_expect("rst2_mk", 10'h01C);

    // Push and pop together while full
    send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    in_valid  = 1'b1;
    in_byte   = 8'h33;
    evt_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    evt_ready = 1'b0;
    chk("pp_ovf", 32'(overflow), 32'h0);
    chk_held("pp", 1'b1, 9'h033, 8'd6);
    pop_expect("pp0", 10'h021);
    pop_expect("pp1", 10'h023);
    pop_expect("pp2", 10'h024);
    pop_expect("pp3", 10'h033);
    chk("pp_empty", 32'(evt_valid), 32'h0);

    // press_count wraps: 6 + 250 presses = 256
    evt_ready = 1'b1;
    for (int i = 0; i < 250; i++) send((i % 2) ? 8'h1C : 8'h32);
    idle(1);
    evt_ready = 1'b0;
    chk("wrap_cnt", 32'(press_count), 32'h0);
    chk("wrap_empty", 32'(evt_valid), 32'h0);
    chk("wrap_ovf", 32'(overflow), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
